// File: rtl/ula_stack_ctrl.sv
// Operand-stack sequencer: accepts PUSH/POP/EXEC/CLEAR commands, owns the stack
// and is the sole driver of the shared combinational ULA inputs.
module ula_stack_ctrl #(
    parameter int DATA_SIZE = 11,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [DATA_SIZE-1:0]     cmd_data,
    input  logic [3:0]               cmd_opcode,
    output logic                     resp_valid,
    output logic [DATA_SIZE-1:0]     resp_data,
    output logic                     resp_err,
    output logic [1:0]               err_code,
    output logic [DATA_SIZE-1:0]     alu_a,
    output logic [DATA_SIZE-1:0]     alu_b,
    output logic [3:0]               alu_opcode,
    input  logic [DATA_SIZE-1:0]     alu_result,
    output logic [$clog2(DEPTH):0]   depth,
    output logic [DATA_SIZE-1:0]     top
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_EXEC  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_OVER    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    localparam logic [3:0] ALU_DIV = 4'd3;
    localparam logic [3:0] ALU_NOT = 4'd9;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, WB, RESP} state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [DATA_SIZE-1:0]   stack_r [DEPTH];
    logic [3:0]             opcode_r;
    logic [DATA_SIZE-1:0]   result_r;

    logic                   accept_s;
    logic                   full_s;
    logic                   is_not_s;
    logic                   load_ill_s;
    logic                   load_under_s;
    logic                   div0_s;
    logic [AW-1:0]          top_idx_s;
    logic [AW-1:0]          sec_idx_s;

    // Decode of stack status and EXEC error conditions
    always_comb begin
        accept_s     = cmd_valid && cmd_ready;
        full_s       = (depth == DW'(DEPTH));
        is_not_s     = (opcode_r == ALU_NOT);
        load_ill_s   = (opcode_r > 4'd9);
        load_under_s = is_not_s ? (depth < DW'(1)) : (depth < DW'(2));
        div0_s       = (alu_opcode == ALU_DIV) && (alu_b == {DATA_SIZE{1'b0}});
        top_idx_s    = depth[AW-1:0] - AW'(1);
        sec_idx_s    = depth[AW-1:0] - AW'(2);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = (cmd_op == OP_EXEC) ? LOAD : RESP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (load_ill_s || load_under_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = CALC;
                end
            end
            CALC: begin
                if (div0_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WB;
                end
            end
            WB:      next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, stack, ULA operand and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cmd_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= {DATA_SIZE{1'b0}};
            resp_err   <= 1'b0;
            err_code   <= ERR_NONE;
            alu_a      <= {DATA_SIZE{1'b0}};
            alu_b      <= {DATA_SIZE{1'b0}};
            alu_opcode <= 4'd0;
            depth      <= {DW{1'b0}};
            top        <= {DATA_SIZE{1'b0}};
            opcode_r   <= 4'd0;
            result_r   <= {DATA_SIZE{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {DATA_SIZE{1'b0}};
            end
        end else begin
            state_r    <= next_state_s;
            cmd_ready  <= (next_state_s == IDLE);
            resp_valid <= (next_state_s == RESP);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opcode_r <= cmd_opcode;
                        resp_err <= 1'b0;
                        err_code <= ERR_NONE;
                        case (cmd_op)
                            OP_PUSH: begin
                                if (full_s) begin
                                    resp_err  <= 1'b1;
                                    err_code  <= ERR_OVER;
                                    resp_data <= {DATA_SIZE{1'b0}};
                                end else begin
                                    stack_r[depth[AW-1:0]] <= cmd_data;
                                    depth     <= depth + DW'(1);
                                    top       <= cmd_data;
                                    resp_data <= cmd_data;
                                end
                            end
                            OP_POP: begin
                                if (depth == {DW{1'b0}}) begin
                                    resp_err  <= 1'b1;
                                    err_code  <= ERR_UNDER;
                                    resp_data <= {DATA_SIZE{1'b0}};
                                end else begin
                                    resp_data <= top;
                                    depth     <= depth - DW'(1);
                                    top       <= (depth >= DW'(2)) ? stack_r[sec_idx_s]
                                                                   : {DATA_SIZE{1'b0}};
                                end
                            end
                            OP_CLEAR: begin
                                depth     <= {DW{1'b0}};
                                top       <= {DATA_SIZE{1'b0}};
                                resp_data <= {DATA_SIZE{1'b0}};
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                LOAD: begin
                    if (load_ill_s || load_under_s) begin
                        resp_err  <= 1'b1;
                        err_code  <= load_ill_s ? ERR_ILLEGAL : ERR_UNDER;
                        resp_data <= {DATA_SIZE{1'b0}};
                    end else begin
                        alu_opcode <= opcode_r;
                        if (is_not_s) begin
                            alu_a <= top;
                            alu_b <= {DATA_SIZE{1'b0}};
                        end else begin
                            alu_a <= stack_r[sec_idx_s];
                            alu_b <= top;
                        end
                    end
                end
                CALC: begin
                    if (div0_s) begin
                        resp_err  <= 1'b1;
                        err_code  <= ERR_ILLEGAL;
                        resp_data <= {DATA_SIZE{1'b0}};
                    end else begin
                        result_r <= alu_result;
                    end
                end
                WB: begin
                    // NOT overwrites the top slot; binary ops collapse two slots into one
                    if (alu_opcode == ALU_NOT) begin
                        stack_r[top_idx_s] <= result_r;
                    end else begin
                        stack_r[sec_idx_s] <= result_r;
                        depth              <= depth - DW'(1);
                    end
                    top       <= result_r;
                    resp_data <= result_r;
                    resp_err  <= 1'b0;
                    err_code  <= ERR_NONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_stack_ctrl.sv
// Directed self-checking bench for ula_stack_ctrl with a behavioural ULA model.
module tb_ula_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [10:0] cmd_data;
    logic [3:0]  cmd_opcode;
    logic        resp_valid;
    logic [10:0] resp_data;
    logic        resp_err;
    logic [1:0]  err_code;
    logic [10:0] alu_a;
    logic [10:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [10:0] alu_result;
    logic [3:0]  depth;
    logic [10:0] top;

    int errors = 0;
    int checks = 0;

    int          lat;
    logic [10:0] rd;
    logic        re;
    logic [1:0]  rc;

    always #5 clk = ~clk;

    ula_stack_ctrl #(.DATA_SIZE(11), .DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_opcode(cmd_opcode),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .err_code(err_code), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .depth(depth), .top(top)
    );

    function automatic logic [10:0] ula_model(input logic [10:0] a, input logic [10:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return (b == 11'd0) ? 11'd0 : a / b;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return a % ((b == 11'd0) ? 11'd1 : b);
            4'd8: return (a < b) ? 11'h7FF : ((a == b) ? 11'd0 : 11'd1);
            4'd9: return (a == 11'd0) ? 11'd1 : 11'd0;
            default: return 11'd0;
        endcase
    endfunction

    assign alu_result = ula_model(alu_a, alu_b, alu_opcode);

    // Issue one command from a negedge; returns cycles from acceptance to resp_valid (99 on timeout)
    task automatic do_cmd(input logic [1:0] op, input logic [10:0] data, input logic [3:0] opc,
                          output int l, output logic [10:0] d, output logic e, output logic [1:0] c);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        l = 99;
        if (cmd_ready === 1'b1) begin
            cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_opcode = opc;
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 11'd0; cmd_opcode = 4'd0;
            n = 1;
            while (resp_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (resp_valid === 1'b1) l = n;
        end
        d = resp_data; e = resp_err; c = err_code;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 11'd0; cmd_opcode = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", cmd_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", resp_valid); end
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL rst_depth got=%0d exp=0", depth); end
        checks++; if ({alu_a, alu_b, alu_opcode, top, resp_data} !== 48'd0) begin errors++; $display("FAIL rst_outs got=%0h exp=0", {alu_a, alu_b, alu_opcode, top, resp_data}); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got=%0b exp=0", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_add();
        do_cmd(2'd0, 11'd5, 4'd0, lat, rd, re, rc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL push_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 11'd5) begin errors++; $display("FAIL push_data got=%0d exp=5", rd); end
        checks++; if (depth !== 4'd1) begin errors++; $display("FAIL push_depth got=%0d exp=1", depth); end
        do_cmd(2'd0, 11'd3, 4'd0, lat, rd, re, rc);
        do_cmd(2'd2, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_lat got=%0d exp=4", lat); end
        checks++; if (rd !== 11'd8) begin errors++; $display("FAIL add_data got=%0d exp=8", rd); end
        checks++; if (re !== 1'b0 || rc !== 2'd0) begin errors++; $display("FAIL add_err got=%0b/%0d exp=0/0", re, rc); end
        checks++; if (depth !== 4'd1 || top !== 11'd8) begin errors++; $display("FAIL add_stack got=%0d/%0d exp=1/8", depth, top); end
        checks++; if (alu_a !== 11'd5 || alu_b !== 11'd3 || alu_opcode !== 4'd0) begin errors++; $display("FAIL add_alu got=%0d/%0d/%0d exp=5/3/0", alu_a, alu_b, alu_opcode); end
    endtask

    task automatic test_cmp();
        do_cmd(2'd3, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (lat !== 1 || rd !== 11'd0 || depth !== 4'd0) begin errors++; $display("FAIL clear got=%0d/%0d/%0d exp=1/0/0", lat, rd, depth); end
        do_cmd(2'd0, 11'd3, 4'd0, lat, rd, re, rc);
        do_cmd(2'd0, 11'd5, 4'd0, lat, rd, re, rc);
        do_cmd(2'd2, 11'd0, 4'd8, lat, rd, re, rc);
        checks++; if (rd !== 11'h7FF) begin errors++; $display("FAIL cmp_data got=%0h exp=7ff", rd); end
        checks++; if (depth !== 4'd1 || top !== 11'h7FF) begin errors++; $display("FAIL cmp_stack got=%0d/%0h exp=1/7ff", depth, top); end
    endtask

    task automatic test_illegal();
        do_cmd(2'd3, 11'd0, 4'd0, lat, rd, re, rc);
        do_cmd(2'd0, 11'd7, 4'd0, lat, rd, re, rc);
        do_cmd(2'd0, 11'd0, 4'd0, lat, rd, re, rc);
        do_cmd(2'd2, 11'd0, 4'd3, lat, rd, re, rc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL div0_lat got=%0d exp=3", lat); end
        checks++; if (re !== 1'b1 || rc !== 2'd3 || rd !== 11'd0) begin errors++; $display("FAIL div0_err got=%0b/%0d/%0d exp=1/3/0", re, rc, rd); end
        checks++; if (depth !== 4'd2 || top !== 11'd0) begin errors++; $display("FAIL div0_stack got=%0d/%0d exp=2/0", depth, top); end
        do_cmd(2'd3, 11'd0, 4'd0, lat, rd, re, rc);
        do_cmd(2'd0, 11'd7, 4'd0, lat, rd, re, rc);
        do_cmd(2'd0, 11'd0, 4'd0, lat, rd, re, rc);
        do_cmd(2'd2, 11'd0, 4'd12, lat, rd, re, rc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ill_lat got=%0d exp=2", lat); end
        checks++; if (re !== 1'b1 || rc !== 2'd3 || depth !== 4'd2) begin errors++; $display("FAIL ill_err got=%0b/%0d/%0d exp=1/3/2", re, rc, depth); end
    endtask

    task automatic test_underflow();
        do_cmd(2'd3, 11'd0, 4'd0, lat, rd, re, rc);
        do_cmd(2'd1, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (re !== 1'b1 || rc !== 2'd1 || lat !== 1) begin errors++; $display("FAIL pop_under got=%0b/%0d/%0d exp=1/1/1", re, rc, lat); end
        do_cmd(2'd0, 11'd1, 4'd0, lat, rd, re, rc);
        do_cmd(2'd2, 11'd0, 4'd2, lat, rd, re, rc);
        checks++; if (re !== 1'b1 || rc !== 2'd1 || lat !== 2) begin errors++; $display("FAIL exec_under got=%0b/%0d/%0d exp=1/1/2", re, rc, lat); end
        checks++; if (depth !== 4'd1 || top !== 11'd1) begin errors++; $display("FAIL under_stack got=%0d/%0d exp=1/1", depth, top); end
        do_cmd(2'd2, 11'd0, 4'd9, lat, rd, re, rc);
        checks++; if (rd !== 11'd0 || re !== 1'b0 || lat !== 4) begin errors++; $display("FAIL not_data got=%0d/%0b/%0d exp=0/0/4", rd, re, lat); end
        checks++; if (depth !== 4'd1 || top !== 11'd0) begin errors++; $display("FAIL not_stack got=%0d/%0d exp=1/0", depth, top); end
        do_cmd(2'd0, 11'd6, 4'd0, lat, rd, re, rc);
        do_cmd(2'd1, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (rd !== 11'd6 || re !== 1'b0 || depth !== 4'd1 || top !== 11'd0) begin errors++; $display("FAIL pop_ok got=%0d/%0b/%0d/%0d exp=6/0/1/0", rd, re, depth, top); end
    endtask

    task automatic test_overflow();
        do_cmd(2'd3, 11'd0, 4'd0, lat, rd, re, rc);
        for (int i = 1; i <= 8; i++) begin
            do_cmd(2'd0, 11'(i), 4'd0, lat, rd, re, rc);
            checks++; if (rd !== 11'(i) || re !== 1'b0) begin errors++; $display("FAIL fill_%0d got=%0d/%0b exp=%0d/0", i, rd, re, i); end
        end
        checks++; if (depth !== 4'd8) begin errors++; $display("FAIL full_depth got=%0d exp=8", depth); end
        do_cmd(2'd0, 11'd9, 4'd0, lat, rd, re, rc);
        checks++; if (re !== 1'b1 || rc !== 2'd2 || rd !== 11'd0) begin errors++; $display("FAIL over_err got=%0b/%0d/%0d exp=1/2/0", re, rc, rd); end
        checks++; if (top !== 11'd8 || depth !== 4'd8) begin errors++; $display("FAIL over_stack got=%0d/%0d exp=8/8", top, depth); end
        do_cmd(2'd1, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (rd !== 11'd8 || top !== 11'd7 || depth !== 4'd7) begin errors++; $display("FAIL full_pop got=%0d/%0d/%0d exp=8/7/7", rd, top, depth); end
        do_cmd(2'd3, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (depth !== 4'd0 || top !== 11'd0 || re !== 1'b0) begin errors++; $display("FAIL clear_full got=%0d/%0d/%0b exp=0/0/0", depth, top, re); end
    endtask

    task automatic test_back_to_back();
        do_cmd(2'd0, 11'd2, 4'd0, lat, rd, re, rc);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_pulse got=%0b/%0b exp=0/1", resp_valid, cmd_ready); end
        checks++; if (resp_data !== 11'd2) begin errors++; $display("FAIL b2b_hold got=%0d exp=2", resp_data); end
        do_cmd(2'd0, 11'd4, 4'd0, lat, rd, re, rc);
        checks++; if (lat !== 1 || rd !== 11'd4) begin errors++; $display("FAIL b2b_push got=%0d/%0d exp=1/4", lat, rd); end
        do_cmd(2'd2, 11'd0, 4'd1, lat, rd, re, rc);
        checks++; if (rd !== 11'h7FE || depth !== 4'd1) begin errors++; $display("FAIL sub_wrap got=%0h/%0d exp=7fe/1", rd, depth); end
    endtask

    task automatic test_reset_exec();
        logic seen;
        int n;
        do_cmd(2'd0, 11'd6, 4'd0, lat, rd, re, rc);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_opcode = 4'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (depth !== 4'd0 || top !== 11'd0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rexec_state got=%0d/%0d/%0b exp=0/0/0", depth, top, cmd_ready); end
        checks++; if ({alu_a, alu_b, alu_opcode, resp_data, resp_err, err_code} !== 40'd0) begin errors++; $display("FAIL rexec_outs got=%0h exp=0", {alu_a, alu_b, alu_opcode, resp_data}); end
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen = seen | resp_valid; end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); seen = seen | resp_valid; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rexec_noresp got=%0b exp=0", seen); end
        do_cmd(2'd1, 11'd0, 4'd0, lat, rd, re, rc);
        checks++; if (rc !== 2'd1 || lat !== 1) begin errors++; $display("FAIL rexec_empty got=%0d/%0d exp=1/1", rc, lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_illegal();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
